// File: rtl/mem_arbiter.sv
// Purpose : two-requester round-robin arbiter/sequencer onto the single primary port of the shared data memory.
// Latency : request sampled at edge k -> gnt + memory strobe in cycle k+1 -> done (and read data) in cycle k+2.
// Backpr. : requesters hold req until gnt; one access in flight, so peak throughput is one access per 3 cycles.
// Optional: define MEM_ARB_FIXED_PRI_EN for fixed priority (requester 0 always wins a tie, no rr_ptr).
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                any_req;
  logic                win;       // 0 = requester 0 wins, 1 = requester 1 wins
  logic                owner;     // requester that owns the access in flight
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                accept;

`ifdef MEM_ARB_FIXED_PRI_EN
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    any_req = req0 | req1;
    win     = ~req0;
  end
`else
  logic rr_ptr;  // requester favoured on the next tie

  // Round-robin pick: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = rr_ptr;
    end else begin
      win = req1;
    end
  end

  // After every grant the loser becomes the favoured requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~win;
    end
  end
`endif

  assign accept = (state == IDLE) && any_req;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE waits for a request, ACCESS and RESP last one cycle each.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's command at the grant; held afterwards so the memory bus does not glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      owner     <= win;
      lat_we    <= win ? we1 : we0;
      lat_addr  <= win ? addr1 : addr0;
      lat_wdata <= win ? wdata1 : wdata0;
    end
  end

  // Capture read data into the owner's register only; the other requester's data is untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if ((state == ACCESS) && !lat_we) begin
      if (owner) begin
        rdata1 <= mem_read_data;
      end else begin
        rdata0 <= mem_read_data;
      end
    end
  end

  // Grant marks the ACCESS cycle, done marks the RESP cycle, strobes only during ACCESS.
  always_comb begin
    gnt0           = (state == ACCESS) && !owner;
    gnt1           = (state == ACCESS) &&  owner;
    done0          = (state == RESP)   && !owner;
    done1          = (state == RESP)   &&  owner;
    mem_write      = (state == ACCESS) &&  lat_we;
    mem_read       = (state == ACCESS) && !lat_we;
    mem_addr       = lat_addr;
    mem_write_data = lat_wdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter against a transaction-level reference model.
// Latency : model expects gnt one cycle after a sampled request (no earlier than 3 cycles after the last gnt), done one cycle later.
// Backpr. : requesters hold req from a per-requester command queue until their gnt is observed.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } op_t;

  logic        clk;
  logic        rst;
  logic        req0, we0, gnt0, done0;
  logic [4:0]  addr0;
  logic [31:0] wdata0, rdata0;
  logic        req1, we1, gnt1, done1;
  logic [4:0]  addr1;
  logic [31:0] wdata1, rdata1;
  logic [4:0]  mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [31:0] tbmem [32] = '{default: 32'd0};

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          cyc = 0;
  int          last_gnt = -100;
  bit          own;
  op_t         cur;
  bit          rr;
  logic [31:0] rmem [32];
  logic [31:0] ref_rd0, ref_rd1;
  bit          pr0, pr1;
  bit          saw_gnt0;
  op_t         q0[$];
  op_t         q1[$];
  int          gseq[$];

  mem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory: synchronous write, combinational read
  always @(posedge clk) if (mem_write) tbmem[mem_addr] <= mem_write_data;
  assign mem_read_data = mem_read ? tbmem[mem_addr] : 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    req0 = (q0.size() != 0);
    req1 = (q1.size() != 0);
    if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data; end
    else begin we0 = 1'b0; addr0 = 5'd0; wdata0 = 32'd0; end
    if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data; end
    else begin we1 = 1'b0; addr1 = 5'd0; wdata1 = 32'd0; end
    pr0 = req0;
    pr1 = req1;
  endtask

  task automatic model_reset();
    last_gnt = cyc - 100;
    own      = 1'b0;
    cur      = '0;
    rr       = 1'b0;
    ref_rd0  = 32'd0;
    ref_rd1  = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    drive_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    model_reset();
    rst = 1'b1;
  endtask

  // one clock cycle: predict from the access rules, compare, then present the next commands
  task automatic step();
    bit  eg, win, ed;
    op_t w;
    @(negedge clk);
    cyc++;
    eg  = (cyc >= last_gnt + 3) && (pr0 || pr1);
`ifdef MEM_ARB_FIXED_PRI_EN
    win = (pr0 && pr1) ? 1'b0 : pr1;
`else
    win = (pr0 && pr1) ? rr : pr1;
`endif
    w = '0;
    if (eg) w = win ? q1[0] : q0[0];
    ed = (cyc == last_gnt + 1);
    if (ed) begin
      if (cur.we) rmem[cur.addr] = cur.data;
      else if (own) ref_rd1 = rmem[cur.addr];
      else ref_rd0 = rmem[cur.addr];
    end
    chk("gnt0", gnt0, eg && !win);
    chk("gnt1", gnt1, eg && win);
    chk("one_gnt", gnt0 && gnt1, 0);
    chk("done0", done0, ed && !own);
    chk("done1", done1, ed && own);
    chk("mem_write", mem_write, eg && w.we);
    chk("mem_read", mem_read, eg && !w.we);
    chk("rdata0", rdata0, ref_rd0);
    chk("rdata1", rdata1, ref_rd1);
    if (eg) begin
      chk("mem_addr_acc", mem_addr, w.addr);
      chk("mem_wdata_acc", mem_write_data, w.data);
      gseq.push_back(int'(win));
      cur      = w;
      own      = win;
      last_gnt = cyc;
      rr       = ~win;
      if (win) void'(q1.pop_front());
      else begin void'(q0.pop_front()); saw_gnt0 = 1'b1; end
    end else begin
      chk("mem_addr_hold", mem_addr, cur.addr);
      chk("mem_wdata_hold", mem_write_data, cur.data);
    end
    drive_inputs();
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || cyc <= last_gnt + 2) && n < 2000) begin
      step();
      n++;
    end
    chk("drain_timeout", n >= 2000, 0);
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.we   = 1'($urandom_range(0, 1));
    o.addr = 5'($urandom_range(0, 31));
    o.data = $urandom;
    return o;
  endfunction

  initial begin
    int n;
    int exp_g [8];
    for (int i = 0; i < 32; i++) rmem[i] = 32'd0;
    rst = 1'b0;
    do_reset();

    // reset in the middle of a write: strobes drop at once, nothing written, no done
    q0.push_back('{we: 1'b1, addr: 5'd6, data: 32'd6});
    saw_gnt0 = 1'b0;
    drive_inputs();
    n = 0;
    while (!saw_gnt0 && n < 10) begin step(); n++; end
    chk("midwr_gnt_seen", saw_gnt0, 1);
    #2 rst = 1'b0;
    #1;
    chk("midwr_mem_write", mem_write, 0);
    chk("midwr_gnt0", gnt0, 0);
    chk("midwr_done0", done0, 0);
    chk("midwr_rdata0", rdata0, 0);
    do_reset();
    repeat (4) step();

    // write then read back, requester 0
    q0.push_back('{we: 1'b1, addr: 5'd6, data: 32'd6});
    drive_inputs();
    drain();
    q0.push_back('{we: 1'b0, addr: 5'd6, data: 32'd0});
    drive_inputs();
    drain();
    chk("rd0_addr6", rdata0, 32'd6);

    // requester 1 reads unwritten words
    for (int a = 0; a < 3; a++) q1.push_back('{we: 1'b0, addr: 5'(a), data: 32'd0});
    drive_inputs();
    drain();
    chk("rd1_unwritten", rdata1, 32'd0);
    chk("rd0_untouched", rdata0, 32'd6);

    // simultaneous requests from reset: requester 0 first
    do_reset();
    gseq.delete();
    for (int i = 0; i < 2; i++) begin q0.push_back(rand_op()); q1.push_back(rand_op()); end
    drive_inputs();
    drain();
    chk("sim_first_is_0", gseq[0], 0);
    chk("sim_second_is_1", gseq[1], 1);

    // back-to-back contention, 4 accesses each
    do_reset();
    gseq.delete();
    for (int i = 0; i < 4; i++) begin q0.push_back(rand_op()); q1.push_back(rand_op()); end
    drive_inputs();
    drain();
`ifdef MEM_ARB_FIXED_PRI_EN
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    chk("b2b_count", gseq.size(), 8);
    for (int i = 0; i < 8 && i < gseq.size(); i++) chk($sformatf("b2b_order%0d", i), gseq[i], exp_g[i]);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 3) q0.push_back(rand_op());
      if ($urandom_range(0, 2) == 0 && q1.size() < 3) q1.push_back(rand_op());
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 32x32 data memory `mem`.
- The memory's primary port is addr / write_data / MemRead / MemWrite / read_data.
- Serialises read and write requests from two masters (e.g. datapath load/store unit and debug/loader port) onto that single port.
- Uses round-robin arbitration, one-cycle memory strobes, and returns read data with a done pulse.
- The memory's second read port (addr2/read_data2) is not touched by this block.

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 32, data word width.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req0  input  1  requester 0 access request; level, held until gnt0.
- we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 high.
- addr0  input  ADDR_W  requester 0 word address.
- wdata0  input  DATA_W  requester 0 write data.
- gnt0  output  1  one-cycle pulse: requester 0 request accepted.
- done0  output  1  one-cycle pulse: requester 0 access complete.
- rdata0  output  DATA_W  requester 0 read data; valid from done0, held until requester 0's next read completes.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1  same as above for requester 1.
- mem_addr  output  ADDR_W  to mem.addr.
- mem_write_data  output  DATA_W  to mem.write_data.
- mem_read  output  1  to mem.MemRead.
- mem_write  output  1  to mem.MemWrite.
- mem_read_data  input  DATA_W  from mem.read_data; combinational w.r.t. mem_addr/mem_read.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; rr_ptr=0 (requester 0 favoured).
  - All outputs 0, including rdata0/rdata1 and latched addr/data/we/owner.
  - Takes effect immediately, mid-access included: mem_write/mem_read drop without waiting for clk; the aborted access produces no gnt/done.
- FSM states IDLE -> ACCESS -> RESP -> IDLE; every state lasts exactly one cycle except IDLE (waits for a request).
- IDLE:
  - If any req is high at a clk edge, select the winner, latch its we/addr/wdata and owner, pulse gnt of the winner (registered, high during the ACCESS cycle), then go to ACCESS.
  - Only one gnt is ever high in a cycle.
- Arbitration:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester rr_ptr points to.
  - rr_ptr is set to the non-winner at every grant.
- ACCESS:
  - Drive mem_addr/mem_write_data from the latched values.
  - Assert mem_write=1 for a write, or mem_read=1 for a read, for exactly this cycle.
  - For a read, capture mem_read_data into the owner's rdata register at the end of the cycle.
  - Then go to RESP.
- RESP:
  - Pulse the owner's done for one cycle (for reads and writes); mem_read=mem_write=0.
  - Then go to IDLE.
- Outside ACCESS:
  - mem_read=mem_write=0.
  - mem_addr/mem_write_data hold their last latched values (no glitching onto the memory).
- Latency: request sampled at edge k -> gnt in cycle k+1 (memory strobe in the same cycle) -> done in cycle k+2. Peak throughput is one access per 3 cycles.
- Requester rules:
  - Deassert req in the gnt cycle or later.
  - A req still high at the first IDLE edge after done counts as a new request.
  - Inputs are sampled only in IDLE; changes at other times are ignored.
- Non-owner rdata is never modified.

Optional Feature:
- Macro MEM_ARB_FIXED_PRI_EN.
- Defined: fixed priority, requester 0 always wins when both are requesting; rr_ptr logic is removed. Requester 1 can starve under continuous req0.
- Undefined (default): round-robin as described under Arbitration.

Test Plan:
- Reset mid-write: assert rst=0 during ACCESS of a write (we0=1, addr0=6) -> mem_write falls immediately; gnt/done/rdata all 0; state IDLE after release.
- Single write then read, requester 0:
  - req0, we0=1, addr0=6, wdata0=6 -> gnt0 next cycle with mem_write=1, mem_addr=6, mem_write_data=6; done0 the cycle after.
  - Then read addr0=6 -> rdata0=6 at done0.
- Read of unwritten locations: requester 1 reads addr1=0, 1, 2 after reset -> rdata1 equals the memory reset contents (0); done1 once per access; rdata0 unchanged.
- Simultaneous requests, round-robin: req0 and req1 both held for two accesses from reset -> requester 0 is granted first, requester 1 second; never two gnts in one cycle.
- Back-to-back contention: both requesters hold req for 4 accesses -> grants alternate 0,1,0,1, spaced exactly 3 cycles apart.
- MEM_ARB_FIXED_PRI_EN defined: same stimulus as the back-to-back test -> grants 0,0,0,0 while req0 stays high; requester 1 is granted only after req0 drops.
